// File: rtl/remote_cmd_sched.sv
`default_nettype none
// ============================================================================
// Module   : remote_cmd_sched
// Brief    : Queued command issuer for the RemoteComm UART master with ACK
//            checking, timeout/retry and emergency-land preemption.
// Revision : 1.0 - initial release
// ============================================================================
module remote_cmd_sched #(
    parameter int         DEPTH     = 8,
    parameter int         TIMEOUT   = 1000000,
    parameter int         MAX_RETRY = 2,
    parameter logic [7:0] ACK       = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [7:0]  push_cmd,
    input  logic [15:0] push_data,
    output logic        full,
    output logic        empty,
    input  logic        estop,
    output logic [7:0]  cmd,
    output logic [15:0] data,
    output logic        send_cmd,
    input  logic        cmd_sent,
    input  logic        resp_rdy,
    input  logic [7:0]  resp,
    output logic        clr_resp_rdy,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        ovf,
    input  logic        clr_err
);

    localparam int              c_AW         = $clog2(DEPTH);
    localparam int              c_CW         = c_AW + 1;
    localparam int              c_TW         = $clog2(TIMEOUT + 1);
    localparam int              c_RW         = $clog2(MAX_RETRY + 2);
    localparam logic [c_CW-1:0] c_DEPTH      = c_CW'(DEPTH);
    localparam logic [c_TW-1:0] c_TIMER_LAST = c_TW'(TIMEOUT - 1);
    localparam logic [c_RW-1:0] c_MAX_RETRY  = c_RW'(MAX_RETRY);
    localparam logic [7:0]      c_E_LAND     = 8'h07;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SEND      = 3'd1,
        S_WAIT_SENT = 3'd2,
        S_WAIT_RESP = 3'd3,
        S_CLR       = 3'd4,
        S_ERROR     = 3'd5
    } state_t;

    state_t            r_state;
    logic [23:0]       r_mem [DEPTH];
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_CW-1:0]   r_count;
    logic [c_TW-1:0]   r_timer;
    logic [c_RW-1:0]   r_retry;
    logic [7:0]        r_cmd;
    logic [15:0]       r_data;
    logic              r_send_cmd;
    logic              r_clr_resp_rdy;
    logic              r_done;
    logic              r_err;
    logic              r_ovf;
    logic              r_esp;
    logic              r_forced;
    logic              r_ack;

    logic w_full;
    logic w_empty;
    logic w_flush;
    logic w_push_ok;
    logic w_ovf_set;
    logic w_waiting;
    logic w_timeout;
    logic w_fail;
    logic w_exhaust;
    logic w_pop;

    assign w_full    = (r_count == c_DEPTH);
    assign w_empty   = (r_count == '0);
    assign w_flush   = (r_state == S_IDLE) && r_esp;
    // A push colliding with the emergency flush is dropped silently.
    assign w_push_ok = push && !w_full && !w_flush;
    assign w_ovf_set = push && w_full && !w_flush;
    assign w_waiting = (r_state == S_WAIT_SENT) || (r_state == S_WAIT_RESP);
    assign w_timeout = w_waiting && (r_timer == c_TIMER_LAST);
    assign w_fail    = w_timeout || ((r_state == S_CLR) && !r_ack);
    assign w_exhaust = (r_retry >= c_MAX_RETRY);
    // The forced E_LAND never came from the queue, so it never pops.
    assign w_pop     = !r_forced &&
                       (((r_state == S_CLR) && r_ack) || (w_fail && w_exhaust));

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= {push_cmd, push_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_cmd          <= '0;
            r_data         <= '0;
            r_send_cmd     <= 1'b0;
            r_clr_resp_rdy <= 1'b0;
            r_done         <= 1'b0;
            r_err          <= 1'b0;
            r_ovf          <= 1'b0;
            r_esp          <= 1'b0;
            r_forced       <= 1'b0;
            r_ack          <= 1'b0;
            r_timer        <= '0;
            r_retry        <= '0;
        end else begin
            r_send_cmd     <= 1'b0;
            r_clr_resp_rdy <= 1'b0;
            r_done         <= 1'b0;

            if (w_flush) begin
                r_esp <= 1'b0;
            end else if (estop) begin
                r_esp <= 1'b1;
            end

            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (clr_err) begin
                r_ovf <= 1'b0;
            end

            if (clr_err) begin
                r_err <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (r_esp) begin
                        r_cmd      <= c_E_LAND;
                        r_data     <= '0;
                        r_forced   <= 1'b1;
                        r_send_cmd <= 1'b1;
                        r_state    <= S_SEND;
                    end else if (!w_empty) begin
                        {r_cmd, r_data} <= r_mem[r_rd_ptr];
                        r_forced        <= 1'b0;
                        r_send_cmd      <= 1'b1;
                        r_state         <= S_SEND;
                    end
                end
                S_SEND: begin
                    r_timer <= '0;
                    r_state <= S_WAIT_SENT;
                end
                S_WAIT_SENT: begin
                    r_timer <= r_timer + 1'b1;
                    if (cmd_sent) begin
                        r_state <= S_WAIT_RESP;
                    end
                end
                S_WAIT_RESP: begin
                    r_timer <= r_timer + 1'b1;
                    if (resp_rdy) begin
                        r_ack          <= (resp == ACK);
                        r_done         <= (resp == ACK);
                        r_clr_resp_rdy <= 1'b1;
                        r_state        <= S_CLR;
                    end
                end
                S_CLR: begin
                    if (r_ack) begin
                        r_retry <= '0;
                        r_state <= S_IDLE;
                    end
                end
                S_ERROR: begin
                    if (clr_err || r_esp) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // Failure overrides whatever the state branch chose this cycle.
            if (w_fail) begin
                r_clr_resp_rdy <= (r_state == S_CLR);
                r_done         <= 1'b0;
                if (!w_exhaust) begin
                    r_retry    <= r_retry + 1'b1;
                    r_send_cmd <= 1'b1;
                    r_state    <= S_SEND;
                end else begin
                    r_retry <= '0;
                    r_err   <= 1'b1;
                    r_state <= S_ERROR;
                end
            end
        end
    end

    assign full         = w_full;
    assign empty        = w_empty;
    assign cmd          = r_cmd;
    assign data         = r_data;
    assign send_cmd     = r_send_cmd;
    assign clr_resp_rdy = r_clr_resp_rdy;
    assign done         = r_done;
    assign err          = r_err;
    assign ovf          = r_ovf;
    assign busy         = (r_state != S_IDLE) && (r_state != S_ERROR);

endmodule
`default_nettype wire

// File: tb/tb_remote_cmd_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_remote_cmd_sched
// Brief    : Scoreboard bench for remote_cmd_sched with a RemoteComm model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_remote_cmd_sched;

    localparam int c_DEPTH     = 8;
    localparam int c_TIMEOUT   = 100;
    localparam int c_MAX_RETRY = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        push = 1'b0;
    logic [7:0]  push_cmd = '0;
    logic [15:0] push_data = '0;
    logic        estop = 1'b0;
    logic        cmd_sent = 1'b0;
    logic        resp_rdy = 1'b0;
    logic [7:0]  resp = '0;
    logic        clr_err = 1'b0;
    logic        full;
    logic        empty;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        send_cmd;
    logic        clr_resp_rdy;
    logic        busy;
    logic        done;
    logic        err;
    logic        ovf;

    remote_cmd_sched #(
        .DEPTH     (c_DEPTH),
        .TIMEOUT   (c_TIMEOUT),
        .MAX_RETRY (c_MAX_RETRY),
        .ACK       (8'hA5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .push         (push),
        .push_cmd     (push_cmd),
        .push_data    (push_data),
        .full         (full),
        .empty        (empty),
        .estop        (estop),
        .cmd          (cmd),
        .data         (data),
        .send_cmd     (send_cmd),
        .cmd_sent     (cmd_sent),
        .resp_rdy     (resp_rdy),
        .resp         (resp),
        .clr_resp_rdy (clr_resp_rdy),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .ovf          (ovf),
        .clr_err      (clr_err)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_send  = 0;
    int          n_done  = 0;
    int          n_clr   = 0;
    int          cyc     = 0;
    int          last_done_cyc = -100;
    int          last_gap = 0;
    int          send_cyc_q[$];
    logic [23:0] exp_q[$];

    // Responder: 0 = ACK, 1 = NACK (8'h00), 2 = silent
    int          rsp_mode = 0;
    bit          rsp_hold = 1'b0;
    int          rsp_cnt  = -1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    // RemoteComm model: cmd_sent two cycles after the strobe, response two later
    initial forever begin
        @(negedge clk);
        if (rst) begin
            cmd_sent = 1'b0;
            resp_rdy = 1'b0;
            resp     = '0;
            rsp_cnt  = -1;
        end else begin
            cmd_sent = 1'b0;
            if (clr_resp_rdy) resp_rdy = 1'b0;
            if (send_cmd) begin
                rsp_cnt = 0;
            end else if (rsp_mode == 2) begin
                rsp_cnt = -1;
            end else if (rsp_cnt >= 0 && !rsp_hold) begin
                rsp_cnt++;
                if (rsp_cnt == 2) cmd_sent = 1'b1;
                if (rsp_cnt == 4) begin
                    resp     = (rsp_mode == 0) ? 8'hA5 : 8'h00;
                    resp_rdy = 1'b1;
                    rsp_cnt  = -1;
                end
            end
        end
    end

    // Scoreboard monitor
    initial forever begin
        logic [23:0] e;
        @(negedge clk);
        if (!rst) begin
            if (send_cmd) begin
                n_send++;
                send_cyc_q.push_back(cyc);
                last_gap = cyc - last_done_cyc;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL send_unexpected: got cmd=%h data=%h, required no send", cmd, data);
                end else if ({cmd, data} !== exp_q[0]) begin
                    n_fail++;
                    $display("FAIL send_payload: got %h, required %h", {cmd, data}, exp_q[0]);
                end
            end
            if (clr_resp_rdy) n_clr++;
            if (done) begin
                n_done++;
                last_done_cyc = cyc;
                n_tests++;
                if (clr_resp_rdy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL done_with_clr: clr_resp_rdy=%b, required 1", clr_resp_rdy);
                end else if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL done_unexpected: got %h, required no done", {cmd, data});
                end else begin
                    e = exp_q.pop_front();
                    if ({cmd, data} !== e) begin
                        n_fail++;
                        $display("FAIL done_payload: got %h, required %h", {cmd, data}, e);
                    end
                end
            end
        end
    end

    task automatic do_reset();
        rsp_hold = 1'b0;
        rsp_mode = 0;
        rst = 1'b1;
        push = 1'b0;
        estop = 1'b0;
        clr_err = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic push_one(input logic [7:0] c, input logic [15:0] d, input bit expect_issue);
        push_cmd  = c;
        push_data = d;
        push      = 1'b1;
        if (expect_issue) exp_q.push_back({c, d});
        @(negedge clk);
        push = 1'b0;
    endtask

    task automatic pulse_clr_err();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({send_cmd, done, clr_resp_rdy, busy, err, ovf, full, empty} !== 8'b0000_0001) begin
            n_fail++;
            $display("FAIL reset_flags: got %b, required 00000001",
                     {send_cmd, done, clr_resp_rdy, busy, err, ovf, full, empty});
        end
        n_tests++;
        if ({cmd, data} !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_cmd_data: got %h, required 000000", {cmd, data});
        end
    endtask

    task automatic test_single();
        int s0 = n_send;
        int d0 = n_done;
        int c0 = n_clr;
        rsp_mode = 0;
        push_one(8'h05, 16'h0100, 1'b1);
        n_tests++;
        if ({empty, send_cmd} !== 2'b00) begin
            n_fail++;
            $display("FAIL single_visible: empty,send_cmd=%b, required 00", {empty, send_cmd});
        end
        @(negedge clk);
        n_tests++;
        if ({send_cmd, busy, cmd, data} !== {2'b11, 24'h050100}) begin
            n_fail++;
            $display("FAIL single_issue: send_cmd=%b busy=%b cmd/data=%h, required 1 1 050100",
                     send_cmd, busy, {cmd, data});
        end
        for (int k = 0; k < 50 && n_done < d0 + 1; k++) @(negedge clk);
        repeat (5) @(negedge clk);
        n_tests++;
        if ((n_send - s0) != 1 || (n_done - d0) != 1 || (n_clr - c0) != 1) begin
            n_fail++;
            $display("FAIL single_counts: sends=%0d dones=%0d clrs=%0d, required 1 1 1",
                     n_send - s0, n_done - d0, n_clr - c0);
        end
        n_tests++;
        if ({empty, busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL single_after: empty,busy=%b, required 10", {empty, busy});
        end
    endtask

    task automatic test_overflow();
        int d0 = n_done;
        rsp_mode = 0;
        rsp_hold = 1'b1;
        for (int i = 0; i < 9; i++) begin
            push_cmd  = 8'h10 + 8'(i);
            push_data = 16'h1000 + 16'(i);
            push      = 1'b1;
            if (i < 8) exp_q.push_back({push_cmd, push_data});
            @(negedge clk);
            if (i == 6 || i == 7) begin
                n_tests++;
                if (full !== (i == 7)) begin
                    n_fail++;
                    $display("FAIL ovf_full_after_%0d: full=%b, required %b", i + 1, full, i == 7);
                end
            end
        end
        push = 1'b0;
        n_tests++;
        if ({ovf, full} !== 2'b11) begin
            n_fail++;
            $display("FAIL ovf_flag: ovf,full=%b, required 11", {ovf, full});
        end
        rsp_hold = 1'b0;
        for (int k = 0; k < 1000 && n_done < d0 + 8; k++) @(negedge clk);
        repeat (5) @(negedge clk);
        n_tests++;
        if ((n_done - d0) != 8 || empty !== 1'b1 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL ovf_drain: dones=%0d empty=%b left=%0d, required 8 1 0",
                     n_done - d0, empty, exp_q.size());
        end
        n_tests++;
        if (last_gap != 2) begin
            n_fail++;
            $display("FAIL back_to_back_gap: got %0d cycles, required 2", last_gap);
        end
        pulse_clr_err();
        n_tests++;
        if (ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear: ovf=%b, required 0", ovf);
        end
    endtask

    task automatic test_nack();
        int s0 = n_send;
        int d0;
        rsp_mode = 1;
        push_one(8'h21, 16'h2121, 1'b1);
        push_one(8'h22, 16'h2222, 1'b1);
        for (int k = 0; k < 300 && err !== 1'b1; k++) @(negedge clk);
        repeat (5) @(negedge clk);
        n_tests++;
        if ({err, busy, empty} !== 3'b100) begin
            n_fail++;
            $display("FAIL nack_error_state: err,busy,empty=%b, required 100", {err, busy, empty});
        end
        n_tests++;
        if ((n_send - s0) != 3) begin
            n_fail++;
            $display("FAIL nack_attempts: got %0d sends, required 3", n_send - s0);
        end
        void'(exp_q.pop_front());
        rsp_mode = 0;
        d0 = n_done;
        pulse_clr_err();
        n_tests++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL nack_clr_err: err=%b, required 0", err);
        end
        for (int k = 0; k < 100 && n_done < d0 + 1; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        n_tests++;
        if ((n_done - d0) != 1 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL nack_next_entry: dones=%0d empty=%b, required 1 1", n_done - d0, empty);
        end
    endtask

    task automatic test_timeout();
        int err_cyc = -1;
        int g;
        rsp_mode = 2;
        send_cyc_q.delete();
        push_one(8'h40, 16'h4444, 1'b1);
        for (int k = 0; k < 500 && err !== 1'b1; k++) @(negedge clk);
        err_cyc = cyc;
        n_tests++;
        if (err !== 1'b1 || send_cyc_q.size() != 3) begin
            n_fail++;
            $display("FAIL timeout_err: err=%b sends=%0d, required 1 3", err, send_cyc_q.size());
        end else begin
            for (int i = 1; i < 3; i++) begin
                g = send_cyc_q[i] - send_cyc_q[i-1];
                n_tests++;
                if (g < 95 || g > 110) begin
                    n_fail++;
                    $display("FAIL timeout_resend_%0d: got %0d cycles, required 95..110", i, g);
                end
            end
            g = err_cyc - send_cyc_q[2];
            n_tests++;
            if (g < 95 || g > 110) begin
                n_fail++;
                $display("FAIL timeout_final: got %0d cycles, required 95..110", g);
            end
        end
        void'(exp_q.pop_front());
        rsp_mode = 0;
        pulse_clr_err();
    endtask

    task automatic test_estop();
        int s0 = n_send;
        int d0 = n_done;
        logic [23:0] e0;
        rsp_mode = 0;
        rsp_hold = 1'b1;
        for (int i = 0; i < 4; i++) push_one(8'h31 + 8'(i), 16'h3100 + 16'(i), 1'b1);
        for (int k = 0; k < 20 && n_send < s0 + 1; k++) @(negedge clk);
        estop = 1'b1;
        @(negedge clk);
        estop = 1'b0;
        e0 = exp_q[0];
        exp_q.delete();
        exp_q.push_back(e0);
        exp_q.push_back({8'h07, 16'h0000});
        repeat (3) @(negedge clk);
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL estop_no_abort: busy=%b, required 1", busy);
        end
        rsp_hold = 1'b0;
        for (int k = 0; k < 100 && n_done < d0 + 2; k++) @(negedge clk);
        n_tests++;
        if ((n_done - d0) != 2 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL estop_flush: dones=%0d empty=%b, required 2 1", n_done - d0, empty);
        end
        repeat (30) @(negedge clk);
        n_tests++;
        if ((n_send - s0) != 2) begin
            n_fail++;
            $display("FAIL estop_rest_dropped: got %0d sends, required 2", n_send - s0);
        end
    endtask

    task automatic test_estop_error();
        int s0;
        int d0;
        rsp_mode = 1;
        push_one(8'h50, 16'h5555, 1'b1);
        for (int k = 0; k < 300 && err !== 1'b1; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        void'(exp_q.pop_front());
        rsp_mode = 0;
        s0 = n_send;
        d0 = n_done;
        exp_q.push_back({8'h07, 16'h0000});
        estop = 1'b1;
        @(negedge clk);
        estop = 1'b0;
        for (int k = 0; k < 100 && n_done < d0 + 1; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        n_tests++;
        if ((n_done - d0) != 1 || (n_send - s0) != 1) begin
            n_fail++;
            $display("FAIL err_estop_issue: dones=%0d sends=%0d, required 1 1", n_done - d0, n_send - s0);
        end
        n_tests++;
        if ({err, empty, busy} !== 3'b110) begin
            n_fail++;
            $display("FAIL err_estop_sticky: err,empty,busy=%b, required 110", {err, empty, busy});
        end
        pulse_clr_err();
        n_tests++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_estop_clear: err=%b, required 0", err);
        end
    endtask

    task automatic test_reset_mid();
        int s0 = n_send;
        rsp_mode = 0;
        rsp_hold = 1'b1;
        push_one(8'h60, 16'h6666, 1'b1);
        push_one(8'h61, 16'h6161, 1'b1);
        for (int k = 0; k < 20 && n_send < s0 + 1; k++) @(negedge clk);
        do_reset();
        n_tests++;
        if ({busy, send_cmd, clr_resp_rdy, empty, err} !== 5'b00010 || {cmd, data} !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_mid: busy,send,clr,empty,err=%b cmd/data=%h, required 00010 000000",
                     {busy, send_cmd, clr_resp_rdy, empty, err}, {cmd, data});
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_nack();
        test_timeout();
        test_estop();
        test_estop_error();
        test_reset_mid();
        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
